// File: rtl/time_pkg.sv
// rtl/time_pkg.sv - shared field codes, FSM states and wrap arithmetic for time_set_reg
// Purpose : definitions shared by time_set_reg and its button helper.
// Contents: FLD_* field-select codes, state_e FSM encoding,
//           wrap_inc / wrap_dec modular step functions (32-bit, caller narrows).
package time_pkg;

  localparam logic [1:0] FLD_HR  = 2'd0;
  localparam logic [1:0] FLD_MIN = 2'd1;
  localparam logic [1:0] FLD_SEC = 2'd2;
  localparam logic [1:0] FLD_SUB = 2'd3;

  typedef enum logic [1:0] {
    ST_TRACK  = 2'd0,
    ST_EDIT   = 2'd1,
    ST_COMMIT = 2'd2
  } state_e;

  // Values already at or above the top legal value wrap to zero, so an
  // out-of-range field is pulled back into range by one press.
  function automatic logic [31:0] wrap_inc(input logic [31:0] value,
                                           input logic [31:0] modulus);
    if (value >= modulus - 32'd1) return 32'd0;
    return value + 32'd1;
  endfunction

  // Zero and any out-of-range value both land on the top legal value.
  function automatic logic [31:0] wrap_dec(input logic [31:0] value,
                                           input logic [31:0] modulus);
    if (value == 32'd0 || value >= modulus) return modulus - 32'd1;
    return value - 32'd1;
  endfunction

endpackage

// File: rtl/btn_repeat.sv
// rtl/btn_repeat.sv - button edge detect with hold-to-repeat step strobe
// Purpose: emits a one-cycle step strobe on a fresh press of btn, then again
//          REPEAT_DLY cycles after the press and every REPEAT_PER cycles while
//          the button stays held.
// Ports  : clk, reset (async, active-high)
//          btn   - debounced button level, synchronous to clk
//          clr   - drops any press in progress; a new rising edge is needed
//          step  - combinational one-cycle step request
module btn_repeat #(
  parameter int unsigned REPEAT_DLY = 50000000,
  parameter int unsigned REPEAT_PER = 10000000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  input  logic clr,
  output logic step
);

  localparam int unsigned CNT_MAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
  localparam int          CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] DLY_C = CNT_W'(REPEAT_DLY);
  localparam logic [CNT_W-1:0] PER_C = CNT_W'(REPEAT_PER);
  localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);

  logic             prev_q, prev_d;
  logic             active_q, active_d;   // a press seen by this channel is still held
  logic             rep_q, rep_d;         // initial delay done, now in repeat cadence
  logic [CNT_W-1:0] cnt_q, cnt_d;         // cycles since the last step
  logic [CNT_W-1:0] thresh;

  always_comb begin
    prev_d   = btn;
    active_d = active_q;
    rep_d    = rep_q;
    cnt_d    = cnt_q;
    step     = 1'b0;
    thresh   = rep_q ? PER_C : DLY_C;
    if (clr || !btn) begin
      active_d = 1'b0;
      rep_d    = 1'b0;
      cnt_d    = '0;
    end else if (!prev_q) begin
      step     = 1'b1;
      active_d = 1'b1;
      rep_d    = 1'b0;
      cnt_d    = ONE_C;
    end else if (active_q) begin
      if (cnt_q >= thresh) begin
        step  = 1'b1;
        rep_d = 1'b1;
        cnt_d = ONE_C;
      end else if (cnt_q != '1) begin
        cnt_d = cnt_q + ONE_C;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_q   <= 1'b0;
      active_q <= 1'b0;
      rep_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      prev_q   <= prev_d;
      active_q <= active_d;
      rep_q    <= rep_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/time_set_reg.sv
// rtl/time_set_reg.sv - time register that tracks the counter or lets the user edit it
// Purpose: in TRACK mirrors the timekeeping counter fields; in EDIT freezes
//          them and steps the selected field with wrap and hold-to-repeat;
//          COMMIT raises load_pulse for one cycle so the counter adopts it.
// Ports  : clk, reset (async, active-high)
//          hr_in/min_in/sec_in/sub_in   - live counter fields
//          set_en, field_sel            - edit request and field to edit
//          inc_btn, dec_btn             - debounced step buttons
//          hr_out/min_out/sec_out/sub_out - registered fields
//          load_pulse, editing          - registered status
module time_set_reg
  import time_pkg::*;
#(
  parameter int unsigned DATA_W     = 14,
  parameter int unsigned HR_MOD     = 24,
  parameter int unsigned MIN_MOD    = 60,
  parameter int unsigned SEC_MOD    = 60,
  parameter int unsigned SUB_MOD    = 100,
  parameter int unsigned REPEAT_DLY = 50000000,
  parameter int unsigned REPEAT_PER = 10000000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] hr_in,
  input  logic [DATA_W-1:0] min_in,
  input  logic [DATA_W-1:0] sec_in,
  input  logic [DATA_W-1:0] sub_in,
  input  logic              set_en,
  input  logic [1:0]        field_sel,
  input  logic              inc_btn,
  input  logic              dec_btn,
  output logic [DATA_W-1:0] hr_out,
  output logic [DATA_W-1:0] min_out,
  output logic [DATA_W-1:0] sec_out,
  output logic [DATA_W-1:0] sub_out,
  output logic              load_pulse,
  output logic              editing
);

  localparam longint unsigned FIELD_TOP = (64'd1 << DATA_W);

  if (DATA_W < 1 || DATA_W > 32 ||
      HR_MOD < 1 || MIN_MOD < 1 || SEC_MOD < 1 || SUB_MOD < 1 ||
      64'(HR_MOD) > FIELD_TOP || 64'(MIN_MOD) > FIELD_TOP ||
      64'(SEC_MOD) > FIELD_TOP || 64'(SUB_MOD) > FIELD_TOP ||
      REPEAT_DLY < 1 || REPEAT_PER < 1) begin : g_param_check
    $error("time_set_reg: DATA_W must be 1..32, each MOD-1 must fit in DATA_W, repeat times >= 1");
  end

  state_e            state_q, state_d;
  logic              load_q, load_d;
  logic              editing_q, editing_d;
  logic [1:0]        sel_q;
  logic [DATA_W-1:0] fld_q [4];
  logic [DATA_W-1:0] fld_d [4];

  logic              rep_clr;
  logic              inc_step, dec_step;
  logic [DATA_W-1:0] sel_val, inc_val, dec_val;
  logic [31:0]       sel_mod;

  // Repeat history is only meaningful in EDIT; chords and a field change
  // mid-hold both force the user to press again before stepping resumes.
  assign rep_clr = (state_q != ST_EDIT) || (inc_btn && dec_btn) || (field_sel != sel_q);

  btn_repeat #(.REPEAT_DLY(REPEAT_DLY), .REPEAT_PER(REPEAT_PER)) u_inc (
    .clk   (clk),
    .reset (reset),
    .btn   (inc_btn),
    .clr   (rep_clr),
    .step  (inc_step)
  );

  btn_repeat #(.REPEAT_DLY(REPEAT_DLY), .REPEAT_PER(REPEAT_PER)) u_dec (
    .clk   (clk),
    .reset (reset),
    .btn   (dec_btn),
    .clr   (rep_clr),
    .step  (dec_step)
  );

  always_comb begin
    sel_val = fld_q[field_sel];
    unique case (field_sel)
      FLD_HR:  sel_mod = 32'(HR_MOD);
      FLD_MIN: sel_mod = 32'(MIN_MOD);
      FLD_SEC: sel_mod = 32'(SEC_MOD);
      FLD_SUB: sel_mod = 32'(SUB_MOD);
    endcase
    inc_val = DATA_W'(wrap_inc(32'(sel_val), sel_mod));
    dec_val = DATA_W'(wrap_dec(32'(sel_val), sel_mod));
  end

  always_comb begin
    state_d   = state_q;
    load_d    = 1'b0;
    editing_d = 1'b0;
    for (int i = 0; i < 4; i++) fld_d[i] = fld_q[i];
    unique case (state_q)
      ST_TRACK: begin
        if (set_en) begin
          state_d   = ST_EDIT;
          editing_d = 1'b1;
        end else begin
          fld_d[0] = hr_in;
          fld_d[1] = min_in;
          fld_d[2] = sec_in;
          fld_d[3] = sub_in;
        end
      end
      ST_EDIT: begin
        if (!set_en) begin
          state_d = ST_COMMIT;
          load_d  = 1'b1;
        end else begin
          editing_d = 1'b1;
          if (inc_step)      fld_d[field_sel] = inc_val;
          else if (dec_step) fld_d[field_sel] = dec_val;
        end
      end
      ST_COMMIT: state_d = ST_TRACK;
      default:   state_d = ST_TRACK;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_TRACK;
      load_q    <= 1'b0;
      editing_q <= 1'b0;
      sel_q     <= FLD_HR;
      for (int i = 0; i < 4; i++) fld_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      load_q    <= load_d;
      editing_q <= editing_d;
      sel_q     <= field_sel;
      for (int i = 0; i < 4; i++) fld_q[i] <= fld_d[i];
    end
  end

  assign hr_out     = fld_q[0];
  assign min_out    = fld_q[1];
  assign sec_out    = fld_q[2];
  assign sub_out    = fld_q[3];
  assign load_pulse = load_q;
  assign editing    = editing_q;

endmodule
